// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues single outstanding word reads, and hands instructions to the core over valid/ready.
// Optional macro MISALIGN_CHECK_EN traps misaligned redirect targets in a sticky ERR state instead of truncating them.
//
// state | meaning
// IDLE  | reset state, moves to REQ on the next edge
// REQ   | imem_req high at pc until imem_ready
// WAIT  | request accepted, waiting for imem_rvalid
// VALID | instruction presented, waiting for instr_ready
// ERR   | misaligned target trapped (MISALIGN_CHECK_EN only), left only by reset
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct75,
  input  logic            PCSrc,
  input  logic [1:0]      J,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] ALUResult,
  output logic            fetch_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID
`ifdef MISALIGN_CHECK_EN
    , ERR
`endif
  } state_t;

  localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
  localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);
  localparam logic [XLEN-1:0] LOW2_CLR = ~XLEN'(3);

  state_t          state, state_next;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next;
  logic            pc_load;
  logic            instr_load;

  // JALR has priority over branch/JAL; JALR drops bit 0 of the computed address
  always_comb begin
    if (J == 2'b10)
      target = ALUResult & BIT0_CLR;
    else if (J == 2'b01 || PCSrc)
      target = pc + ImmExt;
    else
      target = pc + FOUR;
  end

`ifdef MISALIGN_CHECK_EN
  assign pc_next = target;
`else
  assign pc_next = target & LOW2_CLR;
`endif

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (imem_ready) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_load = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (instr_ready) begin
`ifdef MISALIGN_CHECK_EN
          if (target[1:0] != 2'b00) begin
            state_next = ERR;
          end else begin
            pc_load    = 1'b1;
            state_next = REQ;
          end
`else
          pc_load    = 1'b1;
          state_next = REQ;
`endif
        end
      end
`ifdef MISALIGN_CHECK_EN
      ERR: state_next = ERR;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= NOP;
    end else begin
      state <= state_next;
      if (pc_load)    pc    <= pc_next;
      if (instr_load) instr <= imem_rdata;
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);
  assign pc_plus4    = pc + FOUR;
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct75     = instr[30];

`ifdef MISALIGN_CHECK_EN
  assign fetch_err = (state == ERR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table for the main flow plus hand-written reset and JALR sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct75;
  logic        PCSrc;
  logic [1:0]  J;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic        fetch_err;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .pc(pc), .pc_plus4(pc_plus4), .op(op), .funct3(funct3), .funct75(funct75),
    .PCSrc(PCSrc), .J(J), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        ps;
    logic [1:0]  j;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        e_req;
    logic        e_val;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rdy, logic rv, logic [31:0] rd, logic ir, logic ps,
                              logic [1:0] j, logic [31:0] imm, logic [31:0] alu,
                              logic e_req, logic e_val, logic [31:0] e_instr, logic [31:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir; v.ps = ps; v.j = j; v.imm = imm; v.alu = alu;
    v.e_req = e_req; v.e_val = e_val; v.e_instr = e_instr; v.e_pc = e_pc;
    tbl.push_back(v);
  endfunction

  task automatic drive(logic rdy, logic rv, logic [31:0] rd, logic ir, logic ps,
                       logic [1:0] j, logic [31:0] imm, logic [31:0] alu);
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    instr_ready = ir; PCSrc = ps; J = j; ImmExt = imm; ALUResult = alu;
  endtask

  task automatic check(string name, logic e_req, logic e_val, logic [31:0] e_instr,
                       logic [31:0] e_pc, logic e_err);
    logic [31:0] e_p4;
    e_p4 = e_pc + 32'd4;
    vectors++;
    if (imem_req !== e_req || imem_addr !== e_pc || instr_valid !== e_val ||
        instr !== e_instr || pc !== e_pc || pc_plus4 !== e_p4 ||
        op !== e_instr[6:0] || funct3 !== e_instr[14:12] || funct75 !== e_instr[30] ||
        fetch_err !== e_err) begin
      miscompares++;
      $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h op=%h f3=%h f75=%b err=%b; want req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h err=%b",
               name, imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, op, funct3, funct75,
               fetch_err, e_req, e_pc, e_val, e_instr, e_pc, e_p4, e_err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0);

    //   rdy rv rd            ir ps j      imm           alu           req val instr         pc
    add(0, 0, 0,            0, 0, 2'b00, 0,            0,            0, 0, 32'h0000_0013, 32'h0);
    add(1, 0, 0,            1, 0, 2'b00, 0,            0,            1, 0, 32'h0000_0013, 32'h0);
    add(0, 1, 32'h13,       1, 0, 2'b00, 0,            0,            0, 0, 32'h0000_0013, 32'h0);
    add(0, 0, 0,            1, 0, 2'b00, 0,            0,            0, 1, 32'h0000_0013, 32'h0);
    add(1, 0, 0,            0, 0, 2'b00, 0,            0,            1, 0, 32'h0000_0013, 32'h4);
    add(0, 1, 32'h00A00093, 0, 0, 2'b00, 0,            0,            0, 0, 32'h0000_0013, 32'h4);
    add(0, 0, 0,            1, 0, 2'b11, 32'h40,       0,            0, 1, 32'h00A0_0093, 32'h4);
    add(1, 0, 0,            0, 0, 2'b00, 0,            0,            1, 0, 32'h00A0_0093, 32'h8);
    add(0, 1, 32'h00000463, 0, 0, 2'b00, 0,            0,            0, 0, 32'h00A0_0093, 32'h8);
    add(0, 0, 0,            1, 1, 2'b00, 32'h8,        0,            0, 1, 32'h0000_0463, 32'h8);
    add(1, 0, 0,            0, 0, 2'b00, 0,            0,            1, 0, 32'h0000_0463, 32'h10);
    add(0, 1, 32'hFE000AE3, 0, 0, 2'b00, 0,            0,            0, 0, 32'h0000_0463, 32'h10);
    add(0, 0, 0,            1, 1, 2'b00, 32'hFFFFFFF0, 0,            0, 1, 32'hFE00_0AE3, 32'h10);
    // request stalled three cycles with a spurious rvalid in REQ
    add(0, 1, 32'hDEADBEEF, 0, 0, 2'b00, 0,            0,            1, 0, 32'hFE00_0AE3, 32'h0);
    add(0, 0, 0,            0, 0, 2'b00, 0,            0,            1, 0, 32'hFE00_0AE3, 32'h0);
    add(0, 0, 0,            0, 0, 2'b00, 0,            0,            1, 0, 32'hFE00_0AE3, 32'h0);
    add(1, 0, 0,            0, 0, 2'b00, 0,            0,            1, 0, 32'hFE00_0AE3, 32'h0);
    add(0, 0, 0,            0, 0, 2'b00, 0,            0,            0, 0, 32'hFE00_0AE3, 32'h0);
    add(0, 1, 32'h0080006F, 0, 0, 2'b00, 0,            0,            0, 0, 32'hFE00_0AE3, 32'h0);
    // consumer stalls four cycles; redirect inputs and stray rvalid/ready must not matter
    add(0, 0, 0,            0, 0, 2'b01, 32'h100,      0,            0, 1, 32'h0080_006F, 32'h0);
    add(0, 1, 32'hBADBAD00, 0, 1, 2'b01, 32'h100,      0,            0, 1, 32'h0080_006F, 32'h0);
    add(1, 0, 0,            0, 1, 2'b00, 0,            0,            0, 1, 32'h0080_006F, 32'h0);
    add(0, 0, 0,            0, 0, 2'b00, 0,            0,            0, 1, 32'h0080_006F, 32'h0);
    add(0, 0, 0,            1, 0, 2'b01, 32'h20,       0,            0, 1, 32'h0080_006F, 32'h0);
    add(1, 0, 0,            0, 0, 2'b00, 0,            0,            1, 0, 32'h0080_006F, 32'h20);
    add(0, 1, 32'h40005033, 0, 0, 2'b00, 0,            0,            0, 0, 32'h0080_006F, 32'h20);
    add(0, 0, 0,            1, 0, 2'b10, 0,            32'h201,      0, 1, 32'h4000_5033, 32'h20);
    add(1, 0, 0,            0, 0, 2'b00, 0,            0,            1, 0, 32'h4000_5033, 32'h200);
    add(0, 1, 32'h13,       0, 0, 2'b00, 0,            0,            0, 0, 32'h4000_5033, 32'h200);
    add(0, 0, 0,            1, 1, 2'b10, 32'h8,        32'hFFFFFFFD, 0, 1, 32'h0000_0013, 32'h200);
    add(1, 0, 0,            0, 0, 2'b00, 0,            0,            1, 0, 32'h0000_0013, 32'hFFFF_FFFC);
    add(0, 1, 32'h00100073, 0, 0, 2'b00, 0,            0,            0, 0, 32'h0000_0013, 32'hFFFF_FFFC);
    add(0, 0, 0,            1, 0, 2'b00, 0,            0,            0, 1, 32'h0010_0073, 32'hFFFF_FFFC);
    add(0, 0, 0,            0, 0, 2'b00, 0,            0,            1, 0, 32'h0010_0073, 32'h0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].ir, tbl[i].ps, tbl[i].j, tbl[i].imm, tbl[i].alu);
      #1;
      check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_val, tbl[i].e_instr, tbl[i].e_pc, 1'b0);
      @(negedge clk);
    end

    // move to pc=0x40 and stop in WAIT, then reset asynchronously
    drive(1, 0, 0, 0, 0, 2'b00, 0, 0);
    #1 check("pre_rst_req0", 1, 0, 32'h0010_0073, 32'h0, 0);
    @(negedge clk);
    drive(0, 1, 32'h1111_1111, 0, 0, 2'b00, 0, 0);
    #1 check("pre_rst_wait0", 0, 0, 32'h0010_0073, 32'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 2'b00, 32'h40, 0);
    #1 check("pre_rst_valid", 0, 1, 32'h1111_1111, 32'h0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 2'b00, 0, 0);
    #1 check("pre_rst_req40", 1, 0, 32'h1111_1111, 32'h40, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
    #1 check("pre_rst_wait40", 0, 0, 32'h1111_1111, 32'h40, 0);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 0, 0, 32'h0000_0013, 32'h0, 0);
    drive(1, 1, 32'h2222_2222, 0, 0, 2'b00, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_idle", 0, 0, 32'h0000_0013, 32'h0, 0);
    @(negedge clk);
    drive(0, 1, 32'h2222_2222, 0, 0, 2'b00, 0, 0);
    #1 check("rst_first_req", 1, 0, 32'h0000_0013, 32'h0, 0);
    @(negedge clk);
    drive(1, 1, 32'h2222_2222, 0, 0, 2'b00, 0, 0);
    #1 check("rst_req_hold", 1, 0, 32'h0000_0013, 32'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
    #1 check("rst_late_drop", 0, 0, 32'h0000_0013, 32'h0, 0);
    @(negedge clk);

    // JALR to 0x107: truncated to 0x104, or trapped when the check is built in
    drive(0, 1, 32'h0000_80E7, 0, 0, 2'b00, 0, 0);
    #1 check("jalr_wait", 0, 0, 32'h0000_0013, 32'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 2'b10, 0, 32'h0000_0107);
    #1 check("jalr_valid", 0, 1, 32'h0000_80E7, 32'h0, 0);
    @(negedge clk);
`ifdef MISALIGN_CHECK_EN
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h3333_3333, 1, 0, 2'b00, 0, 0);
      #1 check($sformatf("jalr_err%0d", k), 0, 0, 32'h0000_80E7, 32'h0, 1);
      @(negedge clk);
    end
`else
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
    #1 check("jalr_trunc", 1, 0, 32'h0000_80E7, 32'h104, 0);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
